unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one variable-latency memory port between the CPU instruction-fetch requester (I) and data-access requester (D).
- Sits between the CPU's InstructionAddr/Instruction and MemAddress/MemReadData/MemWriteData paths and a single unified memory.
- Serialises accesses and produces a Stall signal so the core holds state until its accesses complete.
- Includes a bus timeout so a memory that never acknowledges cannot hang the core.

Parameters:
- DATA_W, 32, data width of all read/write data buses.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum BUSY cycles without MemAck before abort; 0 disables the timeout.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- IReq  in  1  instruction-fetch request (read only).
- IAddr  in  ADDR_W  fetch address.
- IRdData  out  DATA_W  fetched word, valid while IDone=1.
- IDone  out  1  one-cycle completion pulse for I.
- DReq  in  1  data-access request.
- DWe  in  1  1 = write, 0 = read.
- DAddr  in  ADDR_W  data address.
- DWrData  in  DATA_W  write data.
- DRdData  out  DATA_W  read data, valid while DDone=1.
- DDone  out  1  one-cycle completion pulse for D.
- MemReq  out  1  memory request, held until ack or timeout.
- MemWe  out  1  memory write enable.
- MemAddr  out  ADDR_W  memory address.
- MemWrData  out  DATA_W  memory write data.
- MemRdData  in  DATA_W  memory read data, valid with MemAck.
- MemAck  in  1  one-cycle memory completion.
- BusErr  out  1  high with Done when the access timed out.
- Stall  out  1  core must not advance.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; MemReq, MemWe, IDone, DDone and BusErr = 0; MemAddr, MemWrData, IRdData, DRdData and the timeout counter = 0; owner = D.
  - Applies mid-transaction: MemReq drops immediately, the in-flight access is abandoned, and no Done pulse is produced.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If DReq, or IReq (see priority), latch owner, address, write data and We into the Mem* output registers, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
  - Fixed priority: D over I.
- BUSY:
  - MemReq=1; MemWe/MemAddr/MemWrData held constant.
  - On MemAck: latch MemRdData into the owner's RdData register (writes latch 0), go to RESP. MemReq is 0 from the next cycle.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without MemAck: go to RESP with BusErr=1 and owner RdData=0.
  - Otherwise increment the counter.
- RESP:
  - Owner's Done=1 for exactly this cycle; BusErr valid this cycle only.
  - The non-owner's Done stays 0.
  - Next state is always IDLE.
- Latency: request seen in IDLE at cycle t; MemReq high at t+1; ack at t+1+k gives Done at t+2+k. Minimum 3 cycles per access.
- Requester rules:
  - Hold Req and its address/data stable until Done.
  - Drop Req or change address in the cycle after Done.
  - Dropping Req early does not abort; the access completes and Done still pulses.
- RdData registers hold their value after Done until overwritten by that requester's next access.
- MemAck outside BUSY is ignored.
- Both requests pending: D is served, then I. Each gets its own Done pulse, in order.
- Stall = (IReq & ~IDone) | (DReq & ~DDone), combinational. The core advances on the edge ending the last RESP.
- Counter width: clog2(TIMEOUT+1) bits; no wrap is possible because it stops at TIMEOUT.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration when both IReq and DReq are sampled in IDLE. The requester not served last wins, and the owner register records the last grant. A single request is granted regardless.
- ARB_RR_EN undefined: fixed D-over-I priority as above; I may starve while DReq stays high.

Test Plan:
- I read: IReq=1, IAddr=0x40, MemAck on 2nd BUSY cycle with MemRdData=0x8C010004 -> MemAddr=0x40, MemWe=0; IDone one cycle with IRdData=0x8C010004; Stall=1 until the IDone cycle.
- Simultaneous: IReq with IAddr=0x0 plus DReq with DWe=1, DAddr=0x100, DWrData=0xDEADBEEF, immediate acks -> first MemWe=1/MemAddr=0x100/MemWrData=0xDEADBEEF with DDone; then MemAddr=0x0 with IDone; never both Done in one cycle.
- Timeout: TIMEOUT=4, DReq read, no MemAck -> MemReq high exactly 4 cycles then low; DDone=1 with BusErr=1, DRdData=0; a later MemAck is ignored.
- Reset mid-BUSY: drive Rst=0 for 1 cycle during BUSY -> MemReq=0 asynchronously, no Done pulse; next IReq proceeds normally from IDLE.
- Back-to-back: DReq held for 3 accesses with changing DAddr 0x10, 0x14, 0x18 -> three DDone pulses, each access ≥3 cycles, addresses in order.
- Arbitration: IReq and DReq both held for 4 grants -> ARB_RR_EN defined gives D,I,D,I; undefined gives D,D,D,D.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter for one variable-latency memory port.
// Define ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module unified_mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdData,
    output logic              IDone,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWrData,
    output logic [DATA_W-1:0] DRdData,
    output logic              DDone,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic              MemAck,
    output logic              BusErr,
    output logic              Stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]    state;
    logic          owner;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          grant_any;
    logic          grant_i;
    logic          tmo;

    always_comb begin
        grant_any = IReq | DReq;
`ifdef ARB_RR_EN
        // With both pending, the requester that was not granted last wins.
        grant_i   = IReq & (~DReq | (owner == OWN_D));
`else
        grant_i   = IReq & ~DReq;
`endif
    end

    // Abort fires in the BUSY cycle whose increment would bring the counter to TIMEOUT,
    // so MemReq stays high for exactly TIMEOUT cycles.
    always_comb begin
        cnt_inc = cnt + 1'b1;
        tmo     = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    end

    assign MemReq = (state == BUSY);
    assign Stall  = (IReq & ~IDone) | (DReq & ~DDone);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            owner     <= OWN_D;
            cnt       <= '0;
            MemWe     <= 1'b0;
            MemAddr   <= '0;
            MemWrData <= '0;
            IRdData   <= '0;
            DRdData   <= '0;
            IDone     <= 1'b0;
            DDone     <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            IDone  <= 1'b0;
            DDone  <= 1'b0;
            BusErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_i ? OWN_I : OWN_D;
                        MemWe     <= grant_i ? 1'b0 : DWe;
                        MemAddr   <= grant_i ? IAddr : DAddr;
                        MemWrData <= grant_i ? '0 : DWrData;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (MemAck) begin
                        state <= RESP;
                        if (owner == OWN_I) begin
                            IDone   <= 1'b1;
                            IRdData <= MemWe ? '0 : MemRdData;
                        end else begin
                            DDone   <= 1'b1;
                            DRdData <= MemWe ? '0 : MemRdData;
                        end
                    end else if (tmo) begin
                        state  <= RESP;
                        BusErr <= 1'b1;
                        cnt    <= cnt_inc;
                        if (owner == OWN_I) begin
                            IDone   <= 1'b1;
                            IRdData <= '0;
                        end else begin
                            DDone   <= 1'b1;
                            DRdData <= '0;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus timeout, reset and arbitration sequences.
module tb_unified_mem_arbiter;

    logic        Clk;
    logic        Rst;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRdData;
    logic        IDone;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWrData;
    logic [31:0] DRdData;
    logic        DDone;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic [31:0] MemRdData;
    logic        MemAck;
    logic        BusErr;
    logic        Stall;

    int errors = 0;
    int checks = 0;

    unified_mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .IReq(IReq), .IAddr(IAddr), .IRdData(IRdData), .IDone(IDone),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWrData(DWrData),
        .DRdData(DRdData), .DDone(DDone),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemRdData(MemRdData), .MemAck(MemAck), .BusErr(BusErr), .Stall(Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_idone;
        logic        e_ddone;
        logic        e_berr;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_stall;
    } vec_t;

    localparam int NV = 22;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] grants [4];
        logic [1:0] exp_g  [4];
        int         g;
        int         nreq;
        logic       got;

        // I read, ack on 2nd BUSY cycle
        vec[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
        vec[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
        vec[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8C010004, 1'b1, 1'b0, 32'h40,  32'h0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1};
        vec[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,  32'h0, 1'b1, 1'b0, 1'b0, 32'h8C010004, 32'h0,  1'b0};
        vec[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,  32'h0, 1'b0, 1'b0, 1'b0, 32'h8C010004, 32'h0,  1'b0};
        // simultaneous: D write first, then I read
        vec[5]  = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b1};
        vec[6]  = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b1};
        vec[7]  = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h8C010004, 32'h0, 1'b1};
        vec[8]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b1};
        vec[9]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h11112222, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h8C010004, 32'h0, 1'b1};
        vec[10] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h11112222, 32'h0, 1'b0};
        vec[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h11112222, 32'h0, 1'b0};
        // back-to-back D reads at 0x10, 0x14, 0x18
        vec[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'h0,  1'b1};
        vec[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hA0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'h0,  1'b1};
        vec[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11112222, 32'hA0, 1'b0};
        vec[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'hA0, 1'b1};
        vec[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'hA4, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'hA0, 1'b1};
        vec[17] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11112222, 32'hA4, 1'b0};
        vec[18] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'hA4, 1'b1};
        vec[19] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1, 32'hA8, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'hA4, 1'b1};
        vec[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11112222, 32'hA8, 1'b0};
        vec[21] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11112222, 32'hA8, 1'b0};

        Rst = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0;
        DAddr = '0; DWrData = '0; MemAck = 1'b0; MemRdData = '0;
        #12;
        chk("reset memreq", {31'b0, MemReq}, 32'h0);
        chk("reset memwe", {31'b0, MemWe}, 32'h0);
        chk("reset memaddr", MemAddr, 32'h0);
        chk("reset memwrdata", MemWrData, 32'h0);
        chk("reset idone", {31'b0, IDone}, 32'h0);
        chk("reset ddone", {31'b0, DDone}, 32'h0);
        chk("reset buserr", {31'b0, BusErr}, 32'h0);
        chk("reset irdata", IRdData, 32'h0);
        chk("reset drdata", DRdData, 32'h0);
        chk("reset stall", {31'b0, Stall}, 32'h0);
        #11 Rst = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < NV; i++) begin
            IReq = vec[i].ireq; IAddr = vec[i].iaddr;
            DReq = vec[i].dreq; DWe = vec[i].dwe; DAddr = vec[i].daddr; DWrData = vec[i].dwd;
            MemAck = vec[i].ack; MemRdData = vec[i].mrd;
            #1;
            chk($sformatf("row%0d memreq", i),    {31'b0, MemReq}, {31'b0, vec[i].e_req});
            chk($sformatf("row%0d memwe", i),     {31'b0, MemWe},  {31'b0, vec[i].e_we});
            chk($sformatf("row%0d memaddr", i),   MemAddr,         vec[i].e_addr);
            chk($sformatf("row%0d memwrdata", i), MemWrData,       vec[i].e_wd);
            chk($sformatf("row%0d idone", i),     {31'b0, IDone},  {31'b0, vec[i].e_idone});
            chk($sformatf("row%0d ddone", i),     {31'b0, DDone},  {31'b0, vec[i].e_ddone});
            chk($sformatf("row%0d buserr", i),    {31'b0, BusErr}, {31'b0, vec[i].e_berr});
            chk($sformatf("row%0d irdata", i),    IRdData,         vec[i].e_ird);
            chk($sformatf("row%0d drdata", i),    DRdData,         vec[i].e_drd);
            chk($sformatf("row%0d stall", i),     {31'b0, Stall},  {31'b0, vec[i].e_stall});
            @(posedge Clk); #1;
        end

        // timeout: D read, memory never acknowledges
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h200; MemAck = 1'b0;
        nreq = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge Clk); #1;
            if (MemReq) nreq++;
            if (DDone) begin
                got = 1'b1;
                chk("timeout buserr", {31'b0, BusErr}, 32'h1);
                chk("timeout drdata", DRdData, 32'h0);
                chk("timeout memreq low", {31'b0, MemReq}, 32'h0);
                chk("timeout idone", {31'b0, IDone}, 32'h0);
            end
        end
        chk("timeout done seen", {31'b0, got}, 32'h1);
        chk("timeout memreq cycles", nreq, 32'd4);
        DReq = 1'b0; MemAck = 1'b1; MemRdData = 32'hFFFF0000;
        @(posedge Clk); #1;
        chk("late ack buserr cleared", {31'b0, BusErr}, 32'h0);
        @(posedge Clk); #1;
        MemAck = 1'b0;
        chk("late ack ddone", {31'b0, DDone}, 32'h0);
        chk("late ack drdata", DRdData, 32'h0);
        chk("late ack memreq", {31'b0, MemReq}, 32'h0);

        // reset in the middle of BUSY
        IReq = 1'b1; IAddr = 32'h80;
        @(posedge Clk); #1;
        chk("pre-reset memreq", {31'b0, MemReq}, 32'h1);
        #2 Rst = 1'b0; IReq = 1'b0;
        #1;
        chk("async reset memreq", {31'b0, MemReq}, 32'h0);
        chk("async reset memaddr", MemAddr, 32'h0);
        @(posedge Clk); #1 Rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk); #1;
            chk($sformatf("post-reset idone c%0d", c), {31'b0, IDone}, 32'h0);
            chk($sformatf("post-reset memreq c%0d", c), {31'b0, MemReq}, 32'h0);
        end
        IReq = 1'b1; IAddr = 32'h84;
        @(posedge Clk); #1;
        chk("post-reset busy memreq", {31'b0, MemReq}, 32'h1);
        chk("post-reset busy memaddr", MemAddr, 32'h84);
        MemAck = 1'b1; MemRdData = 32'hCAFE0084;
        @(posedge Clk); #1;
        MemAck = 1'b0;
        chk("post-reset idone", {31'b0, IDone}, 32'h1);
        chk("post-reset irdata", IRdData, 32'hCAFE0084);
        IReq = 1'b0;
        @(posedge Clk); #1;

        // arbitration with both requests held; last grant was I
`ifdef ARB_RR_EN
        exp_g[0] = 2'd2; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd1;
`else
        exp_g[0] = 2'd2; exp_g[1] = 2'd2; exp_g[2] = 2'd2; exp_g[3] = 2'd2;
`endif
        for (int k = 0; k < 4; k++) grants[k] = 2'd0;
        IReq = 1'b1; IAddr = 32'h300; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h304;
        g = 0;
        for (int c = 0; c < 60 && g < 4; c++) begin
            @(posedge Clk); #1;
            if (IDone && DDone) chk("arb both done", 32'h1, 32'h0);
            if (IDone) begin grants[g] = 2'd1; g++; end
            else if (DDone) begin grants[g] = 2'd2; g++; end
            MemAck = MemReq; MemRdData = 32'h5A5A0000;
        end
        MemAck = 1'b0; IReq = 1'b0; DReq = 1'b0;
        chk("arb grant count", g, 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("arb grant %0d (1=I 2=D)", k), {30'b0, grants[k]}, {30'b0, exp_g[k]});
        @(posedge Clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
